uart_tx: RTL and testbench

- 8N1 UART transmitter, LSB first, idle-high line; drives the host-link serial output at the same baud as the link receiver.
- Accepts bytes over a valid/ready handshake into a one-entry holding register, so the next byte can be queued while the current frame shifts out.
- Back-to-back frames go out with no idle gap.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx.sv | 160 ++++++++++++++++
 tb/tb_uart_tx.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default clocking constants and
// a parity helper usable by both the transmitter and a future receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        PAR   = 3'd4
    } uart_state_e;

    localparam int DEF_CLK_FREQ  = 40_000_000;
    localparam int DEF_BAUD_RATE = 1_000_000;

    // Even parity is the XOR of the data bits; odd parity is its complement.
    function automatic logic uart_parity(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-entry holding register and gapless back-to-back frames.
// Optional parity bit after the data bits is enabled with `define UART_TX_PARITY_EN.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = DEF_CLK_FREQ,
    parameter int BAUD_RATE    = DEF_BAUD_RATE,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE,
    parameter int STOP_BITS    = 1
`ifdef UART_TX_PARITY_EN
    ,
    parameter bit PARITY_ODD   = 1'b0
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       busy
);

    localparam logic [15:0] BIT_END   = 16'(CLKS_PER_BIT - 1);
    localparam logic        STOP_LAST = 1'(STOP_BITS - 1);

    uart_state_e state_q, state_d;
    logic [15:0] clk_count_q, clk_count_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        stop_idx_q, stop_idx_d;
    logic        hold_full_q, hold_full_d;
    logic        tx_q, tx_d;
    logic [7:0]  hold_data_q, hold_data_d;
    logic [7:0]  shift_q, shift_d;

    logic        accept;
    logic        load;
    logic        bit_end;

    assign accept   = in_valid && !hold_full_q;
    assign bit_end  = (clk_count_q == BIT_END);
    assign in_ready = !hold_full_q;
    assign busy     = (state_q != IDLE) || hold_full_q;
    assign tx       = tx_q;

    always_comb begin
        state_d     = state_q;
        clk_count_d = clk_count_q + 16'd1;
        bit_idx_d   = bit_idx_q;
        stop_idx_d  = stop_idx_q;
        hold_full_d = hold_full_q;
        tx_d        = tx_q;
        hold_data_d = hold_data_q;
        shift_d     = shift_q;
        load        = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d        = 1'b1;
                clk_count_d = 16'd0;
                load        = hold_full_q;
            end
            START: begin
                if (bit_end) begin
                    tx_d        = shift_q[0];
                    bit_idx_d   = 3'd0;
                    clk_count_d = 16'd0;
                    state_d     = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    clk_count_d = 16'd0;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_d       = uart_parity(shift_q, PARITY_ODD);
                        state_d    = PAR;
`else
                        tx_d       = 1'b1;
                        stop_idx_d = 1'b0;
                        state_d    = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[bit_idx_q + 3'd1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PAR: begin
                if (bit_end) begin
                    tx_d        = 1'b1;
                    stop_idx_d  = 1'b0;
                    clk_count_d = 16'd0;
                    state_d     = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    clk_count_d = 16'd0;
                    if (stop_idx_q == STOP_LAST) begin
                        // A held byte starts its frame on the very next clock: no idle gap.
                        if (hold_full_q) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        stop_idx_d = stop_idx_q + 1'b1;
                    end
                end
            end
            default: begin
                tx_d        = 1'b1;
                clk_count_d = 16'd0;
                state_d     = IDLE;
            end
        endcase

        if (load) begin
            shift_d     = hold_data_q;
            hold_full_d = 1'b0;
            clk_count_d = 16'd0;
            tx_d        = 1'b0;
            state_d     = START;
        end

        // Load and accept are mutually exclusive: accept needs hold_full low, load needs it high.
        if (accept) begin
            hold_data_d = in_data;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            clk_count_q <= 16'd0;
            bit_idx_q   <= 3'd0;
            stop_idx_q  <= 1'b0;
            hold_full_q <= 1'b0;
            tx_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            clk_count_q <= clk_count_d;
            bit_idx_q   <= bit_idx_d;
            stop_idx_q  <= stop_idx_d;
            hold_full_q <= hold_full_d;
            tx_q        <= tx_d;
        end
    end

    // Data-only registers: their contents are meaningless until hold_full qualifies them.
    always_ff @(posedge clk) begin
        hold_data_q <= hold_data_d;
        shift_q     <= shift_d;
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: one instance at default rate, one at 4 clocks/bit with 2 stop bits.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int  CPB_A   = 40;
    localparam int  FRAME_A = (10 + PAR_BITS) * CPB_A;
    localparam logic ODD_B  = 1'b1;

    logic       clk = 1'b0;
    logic       rst_a, rst_b;
    logic [7:0] in_data_a, in_data_b;
    logic       in_valid_a, in_valid_b;
    logic       in_ready_a, in_ready_b;
    logic       tx_a, tx_b;
    logic       busy_a, busy_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_tx u_dut_a (
        .clk      (clk),
        .rst      (rst_a),
        .in_data  (in_data_a),
        .in_valid (in_valid_a),
        .in_ready (in_ready_a),
        .tx       (tx_a),
        .busy     (busy_a)
    );

    uart_tx #(
        .CLKS_PER_BIT (4),
        .STOP_BITS    (2)
`ifdef UART_TX_PARITY_EN
        ,
        .PARITY_ODD   (ODD_B)
`endif
    ) u_dut_b (
        .clk      (clk),
        .rst      (rst_b),
        .in_data  (in_data_b),
        .in_valid (in_valid_b),
        .in_ready (in_ready_b),
        .tx       (tx_b),
        .busy     (busy_b)
    );

    task automatic chk(input int obs, input int exp, input string tag);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic txs(input bit sel);
        return sel ? tx_b : tx_a;
    endfunction

    function automatic logic rdy(input bit sel);
        return sel ? in_ready_b : in_ready_a;
    endfunction

    // Present a byte at a negedge, hold it until accepted, then scramble in_data.
    task automatic send(input bit sel, input logic [7:0] b);
        int n = 0;
        if (sel) begin in_valid_b = 1'b1; in_data_b = b; end
        else     begin in_valid_a = 1'b1; in_data_a = b; end
        while (!rdy(sel) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(int'(n < 2000), 1, "send_handshake");
        @(negedge clk);
        if (sel) begin in_valid_b = 1'b0; in_data_b = ~b; end
        else     begin in_valid_a = 1'b0; in_data_a = ~b; end
    endtask

    // Checks every clock of a frame; returns on the frame's last clock.
    task automatic check_frame(input bit sel, input logic [7:0] b, input bit chained, input string tag);
        logic exp_bits [0:11];
        int cpb   = sel ? 4 : CPB_A;
        int stops = sel ? 2 : 1;
        logic odd = sel ? ODD_B : 1'b0;
        int nb    = 10 + PAR_BITS + stops - 1;
        int n     = 0;
        int bad;
        for (int i = 0; i < 12; i++) exp_bits[i] = 1'b1;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[i+1] = b[i];
        if (PAR_BITS == 1) exp_bits[9] = (^b) ^ odd;
        if (chained) begin
            @(negedge clk);
        end else begin
            do begin
                @(negedge clk);
                n++;
            end while (txs(sel) !== 1'b0 && n < 500);
            chk(int'(txs(sel)), 0, {tag, "_start_timeout"});
        end
        for (int k = 0; k < nb; k++) begin
            bad = 0;
            for (int c = 0; c < cpb; c++) begin
                if (k != 0 || c != 0) @(negedge clk);
                if (txs(sel) !== exp_bits[k]) bad++;
            end
            chk(bad, 0, $sformatf("%s_bit%0d_level%0b_wrong_clocks", tag, k, exp_bits[k]));
        end
    endtask

    initial begin
        int n;
        int lows;
        int busies;
        rst_a = 1'b1; rst_b = 1'b1;
        in_valid_a = 1'b0; in_valid_b = 1'b0;
        in_data_a = 8'h00; in_data_b = 8'h00;
        #1;
        chk(int'(tx_a), 1, "reset_tx_a");
        chk(int'(in_ready_a), 1, "reset_ready_a");
        chk(int'(busy_a), 0, "reset_busy_a");
        chk(int'(tx_b), 1, "reset_tx_b");
        chk(int'(in_ready_b), 1, "reset_ready_b");
        chk(int'(busy_b), 0, "reset_busy_b");
        @(negedge clk); @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;
        repeat (3) @(negedge clk);

        // Single byte 0xA5 at 40 clocks/bit
        fork
            send(1'b0, 8'hA5);
            check_frame(1'b0, 8'hA5, 1'b0, "a5");
        join
        chk(int'(busy_a), 1, "a5_busy_last_clock");
        @(negedge clk);
        chk(int'(busy_a), 0, "a5_busy_after_frame");
        chk(int'(tx_a), 1, "a5_idle_line");
        repeat (5) @(negedge clk);

        // Back-to-back 0x00 then 0xFF with valid held continuously
        fork
            begin
                in_valid_a = 1'b1; in_data_a = 8'h00;
                @(negedge clk);
                chk(int'(in_ready_a), 0, "b2b_ready_after_accept");
                in_data_a = 8'hFF;
                @(negedge clk);
                chk(int'(in_ready_a), 1, "b2b_ready_after_load");
                @(negedge clk);
                chk(int'(in_ready_a), 0, "b2b_ready_after_accept2");
                in_valid_a = 1'b0; in_data_a = 8'h5A;
                n = 0;
                while (!in_ready_a && n < 2000) begin
                    @(negedge clk);
                    n++;
                end
                chk(n, FRAME_A - 1, "b2b_ready_low_clocks");
            end
            begin
                check_frame(1'b0, 8'h00, 1'b0, "b2b_00");
                check_frame(1'b0, 8'hFF, 1'b1, "b2b_ff");
            end
        join
        @(negedge clk);
        chk(int'(busy_a), 0, "b2b_busy_at_800");
        chk(int'(tx_a), 1, "b2b_idle_at_800");
        repeat (5) @(negedge clk);

        // Backpressure: three bytes, each held until accepted
        fork
            begin
                send(1'b0, 8'h11);
                send(1'b0, 8'h22);
                send(1'b0, 8'h33);
            end
            begin
                check_frame(1'b0, 8'h11, 1'b0, "bp_11");
                check_frame(1'b0, 8'h22, 1'b1, "bp_22");
                check_frame(1'b0, 8'h33, 1'b1, "bp_33");
            end
        join
        @(negedge clk);
        chk(int'(busy_a), 0, "bp_busy_after_three");
        chk(int'(tx_a), 1, "bp_idle_after_three");
        repeat (5) @(negedge clk);

`ifdef UART_TX_PARITY_EN
        fork
            send(1'b0, 8'h07);
            check_frame(1'b0, 8'h07, 1'b0, "par_even_07");
        join
        @(negedge clk);
        fork
            send(1'b1, 8'h07);
            check_frame(1'b1, 8'h07, 1'b0, "par_odd_07");
        join
        @(negedge clk);
`endif

        // Reset during bit 3 of 0x3C with 0x55 held
        in_valid_a = 1'b1; in_data_a = 8'h3C;
        @(negedge clk);
        in_data_a = 8'h55;
        @(negedge clk);
        chk(int'(tx_a), 0, "rst_start_bit");
        @(negedge clk);
        in_valid_a = 1'b0;
        repeat (178) @(negedge clk);
        chk(int'(in_ready_a), 0, "rst_byte_held");
        chk(int'(busy_a), 1, "rst_busy_before");
        #2 rst_a = 1'b1;
        #1;
        chk(int'(tx_a), 1, "rst_tx_async");
        chk(int'(in_ready_a), 1, "rst_ready_async");
        chk(int'(busy_a), 0, "rst_busy_async");
        @(negedge clk);
        rst_a = 1'b0;
        lows = 0; busies = 0;
        repeat (600) begin
            @(negedge clk);
            if (tx_a !== 1'b1) lows++;
            if (busy_a !== 1'b0) busies++;
        end
        chk(lows, 0, "rst_no_frame_tx_low_clocks");
        chk(busies, 0, "rst_no_frame_busy_clocks");

        // 4 clocks/bit, 2 stop bits: 0x81
        fork
            send(1'b1, 8'h81);
            check_frame(1'b1, 8'h81, 1'b0, "b_81");
        join
        chk(int'(busy_b), 1, "b_busy_last_clock");
        @(negedge clk);
        chk(int'(busy_b), 0, "b_busy_after_frame");

        // Asynchronous reset during the start bit
        in_valid_b = 1'b1; in_data_b = 8'h81;
        @(negedge clk);
        in_valid_b = 1'b0;
        @(negedge clk);
        chk(int'(tx_b), 0, "b_rst_start_low");
        #2 rst_b = 1'b1;
        #1;
        chk(int'(tx_b), 1, "b_rst_tx_async");
        chk(int'(busy_b), 0, "b_rst_busy_async");
        @(negedge clk);
        rst_b = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
